// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a small input FIFO.
// Frame: start(0), 8 data bits LSB first, optional parity, stop(1).
// Ports:
//   clk, reset     - system clock, asynchronous active-high reset
//   data_in        - byte to transmit
//   valid_in       - data_in valid; accepted when ready_out is high
//   ready_out      - FIFO not full (decoded from registered count)
//   tx             - registered serial line, idles high
//   busy           - transmitter FSM is not idle
//   fifo_count     - occupied FIFO entries
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic          ODD    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          push, pop, empty, bit_end;
  logic [7:0]    head;

  assign fifo_count = count;
  assign ready_out  = (count != C_FULL);
  assign empty      = (count == '0);
  assign push       = valid_in && ready_out;
  assign bit_end    = (timer == T_LAST);
  assign head       = mem[rptr];
  assign busy       = (state != IDLE);
  // Pop from IDLE, or at the stop-bit boundary so the next start bit
  // follows with no idle gap.
  assign pop        = !empty && ((state == IDLE) || (state == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // tx is registered: each transition loads the level of the bit being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          tx    <= 1'b1;
          if (pop) begin
            shreg   <= head;
            par_bit <= (^head) ^ ODD;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else timer <= timer + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else timer <= timer + 1'b1;
        end
        PARITY: begin
          if (bit_end) begin
            timer <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else timer <= timer + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (pop) begin
              shreg   <= head;
              par_bit <= (^head) ^ ODD;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else timer <= timer + 1'b1;
        end
        default: begin
          tx    <= 1'b1;
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (default, even parity,
// odd parity, 2 clocks per bit), table vectors, hand-written corner
// sequences and a randomized scoreboard fed by a behavioural line decoder.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din   [4];
  logic       valid [4];
  logic       ready [4];
  logic       tx    [4];
  logic       busy  [4];
  logic [2:0] cnt   [4];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(16)) u0 (.clk(clk), .reset(reset), .data_in(din[0]), .valid_in(valid[0]),
    .ready_out(ready[0]), .tx(tx[0]), .busy(busy[0]), .fifo_count(cnt[0]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .reset(reset),
    .data_in(din[1]), .valid_in(valid[1]), .ready_out(ready[1]), .tx(tx[1]), .busy(busy[1]),
    .fifo_count(cnt[1]));
  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .reset(reset),
    .data_in(din[2]), .valid_in(valid[2]), .ready_out(ready[2]), .tx(tx[2]), .busy(busy[2]),
    .fifo_count(cnt[2]));
  uart_tx #(.CLKS_PER_BIT(2)) u3 (.clk(clk), .reset(reset), .data_in(din[3]), .valid_in(valid[3]),
    .ready_out(ready[3]), .tx(tx[3]), .busy(busy[3]), .fifo_count(cnt[3]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Line level of frame bit i: start, data LSB first, optional parity, stop.
  function automatic int frame_bit(input logic [7:0] b, input int pe, input int po, input int i);
    if (i == 0) return 0;
    if (i <= 8) return int'(b[i-1]);
    if (pe != 0 && i == 9) return int'(^b) ^ po;
    return 1;
  endfunction

  typedef struct {
    int         sel;
    logic [7:0] b;
    int         cpb;
    int         pe;
    int         po;
    int         flen;
  } vec_t;

  // Per-instance configuration, used by the randomized frames.
  int cfg_cpb [4] = '{16, 16, 16, 2};
  int cfg_pe  [4] = '{0, 1, 1, 0};
  int cfg_po  [4] = '{0, 0, 1, 0};

  // Behavioural receiver on u0: detect start, sample each bit mid-cell.
  bit         rx_en = 1'b0;
  logic [7:0] rxq [$];
  logic [7:0] acc [$];
  int         rx_stop_err = 0;
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (rx_en && tx[0] == 1'b0) begin
        repeat (8) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (16) @(negedge clk);
          rb[j] = tx[0];
        end
        repeat (16) @(negedge clk);
        if (tx[0] != 1'b1) rx_stop_err++;
        rxq.push_back(rb);
      end
    end
  end

  task automatic run_frame(input vec_t v, input string nm);
    int n, errs;
    @(negedge clk);
    din[v.sel] = v.b;
    valid[v.sel] = 1'b1;
    @(negedge clk);
    valid[v.sel] = 1'b0;
    chk($sformatf("%s count after push", nm), int'(cnt[v.sel]), 1);
    chk($sformatf("%s tx before pop", nm), int'(tx[v.sel]), 1);
    @(negedge clk);
    chk($sformatf("%s start low", nm), int'(tx[v.sel]), 0);
    chk($sformatf("%s busy at pop", nm), int'(busy[v.sel]), 1);
    chk($sformatf("%s count after pop", nm), int'(cnt[v.sel]), 0);
    n = 0;
    errs = 0;
    while (busy[v.sel] && n < 2000) begin
      if (n < (10 + v.pe) * v.cpb)
        if (int'(tx[v.sel]) != frame_bit(v.b, v.pe, v.po, n / v.cpb)) errs++;
      n++;
      @(negedge clk);
    end
    chk($sformatf("%s bit errors", nm), errs, 0);
    chk($sformatf("%s busy length", nm), n, v.flen);
    chk($sformatf("%s tx idle after", nm), int'(tx[v.sel]), 1);
  endtask

  task automatic drain0();
    int to = 0;
    while ((busy[0] || cnt[0] != 3'd0) && to < 3000) begin
      @(negedge clk);
      to++;
    end
    chk("drain timeout", int'(to < 3000), 1);
    repeat (20) @(negedge clk);
  endtask

  vec_t vt [10];

  initial begin
    int n, errs, first_hi, first_low, sixth, nacc, to, s;
    vec_t rv;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, errs, first_hi, first_low, sixth, nacc, to, s;
    vec_t rv;
    vt[0] = '{0, 8'hA5, 16, 0, 0, 160};
    vt[1] = '{1, 8'h07, 16, 1, 0, 176};
    vt[2] = '{2, 8'h07, 16, 1, 1, 176};
    vt[3] = '{3, 8'h3C,  2, 0, 0,  20};
    vt[4] = '{0, 8'h00, 16, 0, 0, 160};
    vt[5] = '{0, 8'hFF, 16, 0, 0, 160};
    vt[6] = '{1, 8'h80, 16, 1, 0, 176};
    vt[7] = '{2, 8'h00, 16, 1, 1, 176};
    vt[8] = '{3, 8'hFF,  2, 0, 0,  20};
    vt[9] = '{3, 8'h01,  2, 0, 0,  20};
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      din[i] = 8'h00;
    end

    // Reset state
    #12;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset tx u%0d", i), int'(tx[i]), 1);
      chk($sformatf("reset busy u%0d", i), int'(busy[i]), 0);
      chk($sformatf("reset ready u%0d", i), int'(ready[i]), 1);
      chk($sformatf("reset count u%0d", i), int'(cnt[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    rx_en = 1'b1;

    // Table vectors
    for (int i = 0; i < 10; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    // Randomized single frames against the frame model
    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 3));
      rv = '{s, 8'($urandom), cfg_cpb[s], cfg_pe[s], cfg_po[s], (10 + cfg_pe[s]) * cfg_cpb[s]};
      run_frame(rv, $sformatf("rnd%0d", r));
    end

    // Back-to-back 0x00, 0xFF
    @(negedge clk);
    din[0] = 8'h00;
    valid[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'hFF;
    @(negedge clk);
    valid[0] = 1'b0;
    to = 0;
    while (tx[0] && to < 20) begin
      @(negedge clk);
      to++;
    end
    n = 0;
    errs = 0;
    first_hi = -1;
    while (busy[0] && n < 2000) begin
      if (tx[0] && first_hi < 0) first_hi = n;
      if (n < 320)
        if (int'(tx[0]) != (n < 160 ? frame_bit(8'h00, 0, 0, n / 16)
                                    : frame_bit(8'hFF, 0, 0, (n - 160) / 16))) errs++;
      n++;
      @(negedge clk);
    end
    chk("b2b low run", first_hi, 144);
    chk("b2b bit errors", errs, 0);
    chk("b2b busy length", n, 320);
    repeat (20) @(negedge clk);

    // Backpressure: valid held high, new byte every cycle
    rxq.delete();
    acc.delete();
    nacc = 0;
    first_low = -1;
    sixth = -1;
    for (int c = 0; c < 400 && nacc < 6; c++) begin
      din[0] = 8'(c * 37 + 5);
      valid[0] = 1'b1;
      if (ready[0]) begin
        acc.push_back(din[0]);
        nacc++;
        if (nacc == 6) sixth = c;
      end else if (first_low < 0) first_low = c;
      @(negedge clk);
    end
    valid[0] = 1'b0;
    chk("bp accepted before full", first_low, 5);
    chk("bp sixth accept cycle", sixth, 162);
    drain0();
    chk("bp received count", rxq.size(), 6);
    for (int i = 0; i < 6 && i < rxq.size(); i++)
      chk($sformatf("bp byte%0d", i), int'(rxq[i]), int'(acc[i]));

    // Randomized pushes with random gaps, scoreboarded through the decoder
    rxq.delete();
    acc.delete();
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 200)) @(negedge clk);
      din[0] = 8'($urandom);
      valid[0] = 1'b1;
      to = 0;
      while (!ready[0] && to < 1000) begin
        @(negedge clk);
        to++;
      end
      chk("rnd push timeout", int'(to < 1000), 1);
      acc.push_back(din[0]);
      @(negedge clk);
      valid[0] = 1'b0;
    end
    drain0();
    chk("rnd received count", rxq.size(), 12);
    for (int i = 0; i < 12 && i < rxq.size(); i++)
      chk($sformatf("rnd byte%0d", i), int'(rxq[i]), int'(acc[i]));
    chk("stop bit errors", rx_stop_err, 0);

    // Reset mid-frame during data bit 3 with two bytes queued
    rx_en = 1'b0;
    @(negedge clk);
    din[0] = 8'h55;
    valid[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h12;
    @(negedge clk);
    din[0] = 8'h34;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (70) @(negedge clk);
    chk("midreset queued", int'(cnt[0]), 2);
    chk("midreset busy before", int'(busy[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset tx", int'(tx[0]), 1);
    chk("midreset busy", int'(busy[0]), 0);
    chk("midreset count", int'(cnt[0]), 0);
    chk("midreset ready", int'(ready[0]), 1);
    @(negedge clk);
    reset = 1'b0;
    errs = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx[0] != 1'b1 || busy[0] != 1'b0) errs++;
    end
    chk("post-reset idle", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
